plru_controller: RTL and testbench
==================================

Name: plru_controller

Overview:
- Sequences a dual-port 3-bit-per-set tree-PLRU state array for a 4-way set-associative cache.
- Accepts one lookup per cycle from the cache control FSM:
  - hit → touches the hit way;
  - miss → selects a victim from the PLRU tree and touches it.
- Read-modify-write runs over two pipeline stages. Same-set back-to-back requests are handled by write-to-read forwarding.
- Also provides a whole-array flush sequencer. Sits between the cache FSM and the PLRU array instance.

Parameters:
- S_INDEX, 4, set index width; NUM_SETS = 2**S_INDEX
- WIDTH, 3, PLRU bits per set; fixed at 3 (4 ways); other values unsupported

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; also drives array rst0
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_set  in  S_INDEX  set index
- req_hit  in  1  1 = hit, 0 = miss/allocate
- req_way  in  2  hit way (ignored on miss)
- resp_valid  out  1  one-cycle response pulse
- resp_way  out  2  hit way echoed, or victim way on miss
- flush_req  in  1  start full-array clear
- flush_done  out  1  one-cycle pulse on final flush write
- lru_csb0  out  1  array port0 chip select, active-low
- lru_web0  out  1  array port0 write enable, active-low; tied 1 (read-only port)
- lru_addr0  out  S_INDEX  array port0 address
- lru_din0  out  WIDTH  tied '0
- lru_dout0  in  WIDTH  array port0 read data, combinational from addr0
- lru_csb1  out  1  array port1 chip select, active-low
- lru_web1  out  1  array port1 write enable, active-low
- lru_addr1  out  S_INDEX  array port1 address
- lru_din1  out  WIDTH  array port1 write data
- lru_dout1  in  WIDTH  unused

Behaviour:
- Tree encoding: bit0 = root, bit1 = pair{0,1}, bit2 = pair{2,3}.
  - Victim = bit0 ? {1,bit2} : {0,bit1}.
  - Touch way w: bit0 = ~w[1]; if w[1]=0 then bit1 = ~w[0], else bit2 = ~w[0]; the untouched pair bit is kept.
- FSM states: RUN, FLUSH. Reset → RUN.
  - RUN → FLUSH when flush_req=1.
  - FLUSH → RUN after the write at count = NUM_SETS-1.
- req_ready = (state==RUN) && !flush_req && !rst. flush_req has priority over a same-cycle req_valid.
- Stage A (accept cycle):
  - lru_csb0=0, lru_addr0=req_set.
  - Read bits = lru_dout0, unless stage B is valid with a matching set; then read bits = stage B lru_din1 (forwarding).
  - Set, hit, way and read bits are registered into stage B.
  - When no request is accepted, lru_csb0=1.
- Stage B (next cycle):
  - resp_valid=1; resp_way = hit ? way : victim(bits).
  - lru_csb1=0, lru_web1=0, lru_addr1=set, lru_din1=touch(bits, resp_way).
  - Write commits at the end of this cycle.
- Latency is 1 cycle from accept to resp_valid. Throughput is 1 request/cycle. No response backpressure.
- Port1 idle values: csb1=1, web1=1, addr1=0, din1=0.
- Flush:
  - In the flush_req cycle, any valid stage B write still completes.
  - FLUSH runs exactly NUM_SETS cycles. Count goes 0..NUM_SETS-1, with lru_addr1=count, din1=0, csb1=0, web1=0.
  - flush_done=1 in the final write cycle. req_ready=0 throughout FLUSH.
  - flush_req while in FLUSH is ignored.
- Reset values (immediate on rst assertion):
  - state=RUN, stage B valid=0, count=0.
  - resp_valid=0, resp_way=0, flush_done=0, req_ready=0.
  - lru_csb0=1, lru_web0=1, lru_csb1=1, lru_web1=1, all addresses and data 0.
- Reset during FLUSH aborts the flush: no flush_done. The array clears through its own reset.
- Stage B write and stage A read of the same set in the same cycle must forward. Stage A reads of a different set use the array directly.

Test Plan:
- After reset, miss on set 5 → next cycle resp_valid=1, resp_way=0, port1 writes addr1=5, din1=3'b011.
- Four consecutive-cycle misses on set 5 starting from 000 → resp_way 0,2,1,3; din1 011,110,101,000; requires forwarding with no stall.
- Hit way 2 on set 3 from 000 → resp_way=2, din1=3'b100. Then miss on set 3 → victim way 0, din1=3'b111.
- Populate sets 0–15 with misses, then pulse flush_req → req_ready low 16 cycles, addr1 0..15 with din1=0, flush_done on 16th cycle. A subsequent miss on any set → resp_way=0.
- flush_req and req_valid asserted in the same cycle → request not accepted (req_ready=0) and FLUSH entered. Request accepted in the first RUN cycle after flush_done.
- Assert rst asynchronously at flush count 7 → all outputs reach reset values before the next clk edge, flush_done never pulses. After release, a miss on set 9 → resp_way=0.

Source files
------------

// File: rtl/plru_controller_if.sv
// Request/response and flush handshake between the cache control FSM (master)
// and the PLRU controller (slave).
interface plru_controller_if #(
    parameter int S_INDEX = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [S_INDEX-1:0] req_set;
    logic               req_hit;
    logic [1:0]         req_way;
    logic               resp_valid;
    logic [1:0]         resp_way;
    logic               flush_req;
    logic               flush_done;

    modport master (
        output req_valid, req_set, req_hit, req_way, flush_req,
        input  req_ready, resp_valid, resp_way, flush_done
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_way, flush_req,
        output req_ready, resp_valid, resp_way, flush_done
    );
endinterface

// File: rtl/plru_controller.sv
// Two-stage read-modify-write sequencer for a 3-bit tree-PLRU state array
// (4-way cache), with same-set forwarding and a whole-array flush.
module plru_controller #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 3
) (
    input  logic               clk,
    input  logic               rst,
    plru_controller_if.slave   bus,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    output logic [WIDTH-1:0]   lru_din0,
    input  logic [WIDTH-1:0]   lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output logic [WIDTH-1:0]   lru_din1,
    input  logic [WIDTH-1:0]   lru_dout1
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);
    localparam logic [S_INDEX-1:0] PENULT_SET = S_INDEX'(NUM_SETS - 2);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state_reg;
    logic [S_INDEX-1:0] count_reg;
    logic               resp_valid_reg;
    logic [1:0]         resp_way_reg;
    logic               flush_done_reg;
    logic               csb1_reg;
    logic               web1_reg;
    logic [S_INDEX-1:0] addr1_reg;
    logic [WIDTH-1:0]   din1_reg;

    logic               req_ready_next;
    logic               accept;
    logic               fwd_hit;
    logic [WIDTH-1:0]   read_bits;
    logic [1:0]         way_next;
    logic [WIDTH-1:0]   bits_next;
    logic               unused_dout1;

    function automatic logic [1:0] victim(input logic [WIDTH-1:0] b);
        return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    endfunction

    function automatic logic [WIDTH-1:0] touch(input logic [WIDTH-1:0] b, input logic [1:0] w);
        logic [WIDTH-1:0] t;
        t    = b;
        t[0] = ~w[1];
        if (!w[1]) t[1] = ~w[0];
        else       t[2] = ~w[0];
        return t;
    endfunction

    assign req_ready_next = (state_reg == RUN) && !bus.flush_req && !rst;
    assign accept         = bus.req_valid && req_ready_next;

    // Stage B is writing this set at the end of the cycle, so the array copy is stale.
    assign fwd_hit   = resp_valid_reg && (addr1_reg == bus.req_set);
    assign read_bits = fwd_hit ? din1_reg : lru_dout0;
    assign way_next  = bus.req_hit ? bus.req_way : victim(read_bits);
    assign bits_next = touch(read_bits, way_next);

    assign lru_csb0  = !accept;
    assign lru_web0  = 1'b1;
    assign lru_addr0 = accept ? bus.req_set : '0;
    assign lru_din0  = '0;

    assign lru_csb1  = csb1_reg;
    assign lru_web1  = web1_reg;
    assign lru_addr1 = addr1_reg;
    assign lru_din1  = din1_reg;

    assign bus.req_ready  = req_ready_next;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_way   = resp_way_reg;
    assign bus.flush_done = flush_done_reg;

    assign unused_dout1 = ^lru_dout1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            count_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_way_reg   <= 2'd0;
            flush_done_reg <= 1'b0;
            csb1_reg       <= 1'b1;
            web1_reg       <= 1'b1;
            addr1_reg      <= '0;
            din1_reg       <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.flush_req) begin
                        state_reg      <= FLUSH;
                        count_reg      <= '0;
                        resp_valid_reg <= 1'b0;
                        resp_way_reg   <= 2'd0;
                        flush_done_reg <= 1'b0;
                        csb1_reg       <= 1'b0;
                        web1_reg       <= 1'b0;
                        addr1_reg      <= '0;
                        din1_reg       <= '0;
                    end else if (accept) begin
                        resp_valid_reg <= 1'b1;
                        resp_way_reg   <= way_next;
                        csb1_reg       <= 1'b0;
                        web1_reg       <= 1'b0;
                        addr1_reg      <= bus.req_set;
                        din1_reg       <= bits_next;
                    end else begin
                        resp_valid_reg <= 1'b0;
                        resp_way_reg   <= 2'd0;
                        csb1_reg       <= 1'b1;
                        web1_reg       <= 1'b1;
                        addr1_reg      <= '0;
                        din1_reg       <= '0;
                    end
                end
                FLUSH: begin
                    if (count_reg == LAST_SET) begin
                        state_reg      <= RUN;
                        count_reg      <= '0;
                        flush_done_reg <= 1'b0;
                        csb1_reg       <= 1'b1;
                        web1_reg       <= 1'b1;
                        addr1_reg      <= '0;
                    end else begin
                        count_reg      <= count_reg + 1'b1;
                        addr1_reg      <= count_reg + 1'b1;
                        // Pulse lands on the cycle that writes the last set.
                        flush_done_reg <= (count_reg == PENULT_SET);
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_plru_controller.sv
// Bench for plru_controller: behavioural array, sequential PLRU reference model
// and an expectation queue drained on each response.
module tb_plru_controller;
    localparam int S_INDEX  = 4;
    localparam int NUM_SETS = 16;
    localparam int WIDTH    = 3;

    logic               clk;
    logic               rst;
    logic               lru_csb0, lru_web0, lru_csb1, lru_web1;
    logic [S_INDEX-1:0] lru_addr0, lru_addr1;
    logic [WIDTH-1:0]   lru_din0, lru_din1, lru_dout0, lru_dout1;
    logic [WIDTH-1:0]   mem [NUM_SETS];
    logic [2:0]         model [NUM_SETS];

    typedef struct packed {
        logic [3:0] set;
        logic [1:0] way;
        logic [2:0] din;
    } exp_t;
    exp_t sb_q[$];

    int vectors;
    int miscompares;

    plru_controller_if #(.S_INDEX(S_INDEX)) bus();

    plru_controller #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lru_csb0  (lru_csb0),
        .lru_web0  (lru_web0),
        .lru_addr0 (lru_addr0),
        .lru_din0  (lru_din0),
        .lru_dout0 (lru_dout0),
        .lru_csb1  (lru_csb1),
        .lru_web1  (lru_web1),
        .lru_addr1 (lru_addr1),
        .lru_din1  (lru_din1),
        .lru_dout1 (lru_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lru_dout0 = mem[lru_addr0];
    assign lru_dout1 = mem[lru_addr1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
        end else if (!lru_csb1 && !lru_web1) begin
            mem[lru_addr1] <= lru_din1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_victim(input logic [2:0] b);
        if (b[0] == 1'b0) return b[1] ? 2'd1 : 2'd0;
        else              return b[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        case (w)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_SETS; i++) model[i] = 3'b000;
    endfunction

    function automatic void push_exp(input logic [3:0] set, input logic hit, input logic [1:0] way);
        exp_t e;
        e.set = set;
        e.way = hit ? way : m_victim(model[set]);
        e.din = m_touch(model[set], e.way);
        model[set] = e.din;
        sb_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_size", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("resp set=%0d way=%0d din=%b (exp way=%0d din=%b)",
                         lru_addr1, bus.resp_way, lru_din1, e.way, e.din);
                check_val("resp_way", bus.resp_way, e.way);
                check_val("addr1", lru_addr1, e.set);
                check_val("din1", lru_din1, e.din);
                check_val("csb1_wr", lru_csb1, 0);
                check_val("web1_wr", lru_web1, 0);
            end
        end
    end

    task automatic check_reset_vals();
        check_val("rst_req_ready", bus.req_ready, 0);
        check_val("rst_resp_valid", bus.resp_valid, 0);
        check_val("rst_resp_way", bus.resp_way, 0);
        check_val("rst_flush_done", bus.flush_done, 0);
        check_val("rst_csb0", lru_csb0, 1);
        check_val("rst_web0", lru_web0, 1);
        check_val("rst_addr0", lru_addr0, 0);
        check_val("rst_din0", lru_din0, 0);
        check_val("rst_csb1", lru_csb1, 1);
        check_val("rst_web1", lru_web1, 1);
        check_val("rst_addr1", lru_addr1, 0);
        check_val("rst_din1", lru_din1, 0);
    endtask

    // Called at a negedge; holds reset for two cycles and releases on a negedge.
    task automatic apply_reset();
        bus.req_valid = 1'b0;
        bus.flush_req = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        sb_q.delete();
        #1 check_val("ready_after_rst", bus.req_ready, 1);
        @(negedge clk);
    endtask

    task automatic do_req(input logic [3:0] set, input logic hit, input logic [1:0] way);
        bit accepted;
        accepted      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_set   = set;
        bus.req_hit   = hit;
        bus.req_way   = way;
        for (int c = 0; c < 40 && !accepted; c++) begin
            #4;
            if (bus.req_ready) begin
                check_val("csb0_acc", lru_csb0, 0);
                check_val("addr0_acc", lru_addr0, set);
                push_exp(set, hit, way);
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        check_val("req_accept", accepted, 1);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.flush_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // abort_at < 0 runs the flush to completion; otherwise rst is pulsed at that count.
    task automatic do_flush(input bit with_req, input int abort_at);
        bus.flush_req = 1'b1;
        bus.req_valid = with_req;
        bus.req_set   = 4'd7;
        bus.req_hit   = 1'b0;
        bus.req_way   = 2'd0;
        #4;
        check_val("ready_on_flush_req", bus.req_ready, 0);
        check_val("csb0_on_flush_req", lru_csb0, 1);
        @(negedge clk);
        bus.flush_req = 1'b0;
        model_clear();
        for (int i = 0; i < NUM_SETS; i++) begin
            check_val("flush_ready", bus.req_ready, 0);
            check_val("flush_addr1", lru_addr1, i);
            check_val("flush_din1", lru_din1, 0);
            check_val("flush_csb1", lru_csb1, 0);
            check_val("flush_web1", lru_web1, 0);
            check_val("flush_done", bus.flush_done, (i == NUM_SETS - 1) ? 1 : 0);
            check_val("flush_resp_valid", bus.resp_valid, 0);
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset_vals();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                bus.req_valid = 1'b0;
                sb_q.delete();
                #1 check_val("ready_after_abort", bus.req_ready, 1);
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    check_val("no_done_after_abort", bus.flush_done, 0);
                end
                $display("flush aborted at count %0d", i);
                return;
            end
            @(negedge clk);
        end
        $display("flush complete");
        check_val("flush_done_after", bus.flush_done, 0);
        if (with_req) begin
            #4;
            check_val("ready_after_flush", bus.req_ready, 1);
            if (bus.req_ready) push_exp(4'd7, 1'b0, 2'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        bus.req_valid = 1'b0;
        bus.req_set   = '0;
        bus.req_hit   = 1'b0;
        bus.req_way   = 2'd0;
        bus.flush_req = 1'b0;
        model_clear();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("ready_after_rst", bus.req_ready, 1);
        @(negedge clk);

        // Single miss on a freshly reset set.
        do_req(4'd5, 1'b0, 2'd0);
        idle(2);

        // Back-to-back misses on one set exercise forwarding every cycle.
        apply_reset();
        for (int i = 0; i < 4; i++) do_req(4'd5, 1'b0, 2'd0);
        idle(2);

        // Hit way 2 then an immediate miss on the same set.
        do_req(4'd3, 1'b1, 2'd2);
        do_req(4'd3, 1'b0, 2'd0);
        idle(2);

        // Populate every set, then flush with a stage-B write in flight.
        for (int s = 0; s < NUM_SETS; s++) do_req(4'(s), 1'b0, 2'd0);
        do_flush(1'b0, -1);
        do_req(4'd0, 1'b0, 2'd0);
        do_req(4'd9, 1'b0, 2'd0);
        do_req(4'd15, 1'b0, 2'd0);
        idle(2);

        // Flush and request in the same cycle: request waits for the first RUN cycle.
        do_flush(1'b1, -1);
        idle(2);

        // Mixed traffic over a few sets with random gaps.
        for (int n = 0; n < 60; n++) begin
            do_req(4'(2 + $urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        // Reset in the middle of a flush.
        do_req(4'd9, 1'b0, 2'd0);
        idle(1);
        do_flush(1'b0, 7);
        do_req(4'd9, 1'b0, 2'd0);
        idle(3);

        check_val("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
